// File: rtl/card_click_decoder.sv
// Maps a left-button click to the 4-bit address of the card under the cursor.
// The grid is searched one column, then one row, per cycle, so no dividers are needed.
module card_click_decoder #(
  parameter int GRID_X = 122,
  parameter int GRID_Y = 54,
  parameter int CARD_W = 180,
  parameter int CARD_H = 150,
  parameter int GAP_X  = 20,
  parameter int GAP_Y  = 20,
  parameter int COLS   = 4,
  parameter int ROWS   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        left,
  input  logic [15:0] card_locked,
  output logic        card_pressed,
  output logic        card_miss,
  output logic [3:0]  card_address,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_COL  = 2'd1,
    S_ROW  = 2'd2,
    S_EMIT = 2'd3
  } state_t;

  localparam logic [11:0] LP_GX      = 12'(GRID_X);
  localparam logic [11:0] LP_GY      = 12'(GRID_Y);
  localparam logic [12:0] LP_CW      = 13'(CARD_W);
  localparam logic [12:0] LP_CH      = 13'(CARD_H);
  localparam logic [11:0] LP_PITCH_X = 12'(CARD_W + GAP_X);
  localparam logic [11:0] LP_PITCH_Y = 12'(CARD_H + GAP_Y);
  localparam logic [3:0]  LP_LAST_C  = 4'(COLS - 1);
  localparam logic [3:0]  LP_LAST_R  = 4'(ROWS - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_left_d;
  logic [11:0] r_x;
  logic [11:0] r_y;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic [11:0] r_lo;
  logic [11:0] w_lo_nxt;
  logic [3:0]  r_col;
  logic [3:0]  w_col_nxt;
  logic        r_pressed;
  logic        w_pressed_nxt;
  logic        r_miss;
  logic        w_miss_nxt;
  logic [3:0]  r_addr;
  logic [3:0]  w_addr_nxt;
  logic        r_busy;

  logic        w_click;
  logic        w_in_row;
  logic [11:0] w_val;
  logic [12:0] w_span;
  logic [11:0] w_pitch;
  logic [3:0]  w_last;
  logic        w_below;
  logic        w_inside;
  logic [3:0]  w_addr;

  assign w_click  = left & ~r_left_d & enable & (r_state == S_IDLE);
  assign w_in_row = (r_state == S_ROW);
  assign w_val    = w_in_row ? r_y : r_x;
  assign w_span   = w_in_row ? LP_CH : LP_CW;
  assign w_pitch  = w_in_row ? LP_PITCH_Y : LP_PITCH_X;
  assign w_last   = w_in_row ? LP_LAST_R : LP_LAST_C;
  assign w_below  = (w_val < r_lo);
  // 13-bit compare so lo+span at the far edge of the screen cannot wrap.
  assign w_inside = ({1'b0, w_val} < ({1'b0, r_lo} + w_span));
  assign w_addr   = 4'(int'(r_cnt) * COLS + int'(r_col));

  // Next-state, search counters and registered-pulse decisions.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_lo_nxt      = r_lo;
    w_col_nxt     = r_col;
    w_pressed_nxt = 1'b0;
    w_miss_nxt    = 1'b0;
    w_addr_nxt    = r_addr;
    case (r_state)
      S_IDLE: begin
        if (w_click) begin
          w_state_nxt = S_COL;
          w_cnt_nxt   = 4'd0;
          w_lo_nxt    = LP_GX;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_COL, S_ROW: begin
        if (!enable) begin
          w_state_nxt = S_IDLE;
        end else if (w_below) begin
          w_state_nxt = S_EMIT;
          w_miss_nxt  = 1'b1;
        end else if (w_inside) begin
          if (!w_in_row) begin
            w_state_nxt = S_ROW;
            w_col_nxt   = r_cnt;
            w_cnt_nxt   = 4'd0;
            w_lo_nxt    = LP_GY;
          end else if (card_locked[w_addr]) begin
            w_state_nxt = S_EMIT;
            w_miss_nxt  = 1'b1;
          end else begin
            w_state_nxt   = S_EMIT;
            w_pressed_nxt = 1'b1;
            w_addr_nxt    = w_addr;
          end
        end else if (r_cnt == w_last) begin
          w_state_nxt = S_EMIT;
          w_miss_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
          w_lo_nxt  = r_lo + w_pitch;
        end
      end
      S_EMIT: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, latched cursor position and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_left_d  <= 1'b0;
      r_x       <= 12'd0;
      r_y       <= 12'd0;
      r_cnt     <= 4'd0;
      r_lo      <= 12'd0;
      r_col     <= 4'd0;
      r_pressed <= 1'b0;
      r_miss    <= 1'b0;
      r_addr    <= 4'd0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_left_d  <= left;
      r_cnt     <= w_cnt_nxt;
      r_lo      <= w_lo_nxt;
      r_col     <= w_col_nxt;
      r_pressed <= w_pressed_nxt;
      r_miss    <= w_miss_nxt;
      r_addr    <= w_addr_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
      if (w_click) begin
        r_x <= xpos;
        r_y <= ypos;
      end
    end
  end

  assign card_pressed = r_pressed;
  assign card_miss    = r_miss;
  assign card_address = r_addr;
  assign busy         = r_busy;

endmodule

// File: tb/tb_card_click_decoder.sv
// Scoreboard bench for card_click_decoder: a division-based geometry model predicts
// each click's outcome, and a negedge monitor pops and compares every pulse.
module tb_card_click_decoder;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        left;
  logic [15:0] card_locked;
  logic        card_pressed;
  logic        card_miss;
  logic [3:0]  card_address;
  logic        busy;

  typedef struct {
    bit         pressed;
    logic [3:0] addr;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   total;
  int   bad;
  int   cyc;
  logic [3:0] exp_addr;

  card_click_decoder dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .xpos         (xpos),
    .ypos         (ypos),
    .left         (left),
    .card_locked  (card_locked),
    .card_pressed (card_pressed),
    .card_miss    (card_miss),
    .card_address (card_address),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference geometry: pitch 200 x 170 starting at (122,54), cards 180 x 150.
  function automatic void model(input int x, input int y, input logic [15:0] lk,
                                output bit pr, output int addr, output int lat);
    int col;
    int row;
    pr   = 1'b0;
    addr = 0;
    lat  = 0;
    if (x >= 122 && y >= 54) begin
      col = (x - 122) / 200;
      row = (y - 54) / 170;
      if (col < 4 && row < 4 && ((x - 122) % 200) < 180 && ((y - 54) % 170) < 150) begin
        addr = row * 4 + col;
        if (!lk[addr]) begin
          pr  = 1'b1;
          lat = col + row + 3;
        end
      end
    end
  endfunction

  task automatic push_expect(input int x, input int y, input int c_now);
    bit   pr;
    int   a;
    int   lat;
    exp_t e;
    model(x, y, card_locked, pr, a, lat);
    if (pr) exp_addr = 4'(a);
    e.pressed = pr;
    e.addr    = exp_addr;
    e.cyc     = pr ? c_now + lat : -1;
    q.push_back(e);
  endtask

  task automatic click(input int x, input int y, input bit expect_it);
    @(posedge clk); #1;
    xpos = 12'(x);
    ypos = 12'(y);
    left = 1'b1;
    if (expect_it) push_expect(x, y, cyc);
    @(posedge clk); #1;
    left = 1'b0;
    xpos = 12'($urandom_range(0, 4095));
    ypos = 12'($urandom_range(0, 4095));
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    check_val("drain", 32'(q.size()), 32'd0);
  endtask

  // Pulse monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst && (card_pressed || card_miss)) begin
      check_val("exclusive", 32'(card_pressed & card_miss), 32'd0);
      if (q.size() == 0) begin
        check_val("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check_val("kind", 32'(card_pressed), 32'(e.pressed));
        check_val("addr", 32'(card_address), 32'(e.addr));
        if (e.cyc >= 0) check_val("latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int xs[10] = '{122, 121, 302, 301, 901, 902, 122, 530, 750, 500};
  int ys[10] = '{54,  60,  60,  203, 713, 713, 204, 400, 575, 223};

  initial begin
    total = 0;
    bad = 0;
    exp_addr = 4'd0;
    rst = 1'b0;
    enable = 1'b0;
    left = 1'b0;
    xpos = 12'd0;
    ypos = 12'd0;
    card_locked = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_pressed", 32'(card_pressed), 32'd0);
    check_val("rst_miss", 32'(card_miss), 32'd0);
    check_val("rst_addr", 32'(card_address), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    enable = 1'b1;

    // Top-left card, 3-cycle latency, busy for exactly 3 cycles.
    click(130, 60, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("busy_t1", 32'(busy), (i < 3) ? 32'd1 : 32'd0);
    end
    wait_done();

    click(890, 700, 1'b1);
    wait_done();

    click(310, 100, 1'b1);
    wait_done();
    click(1000, 700, 1'b1);
    wait_done();
    click(130, 40, 1'b1);
    wait_done();

    card_locked = 16'h0020;
    click(330, 230, 1'b1);
    wait_done();
    card_locked = 16'h0000;
    click(330, 230, 1'b1);
    wait_done();

    // Pixel-boundary table.
    for (int i = 0; i < 10; i++) begin
      click(xs[i], ys[i], 1'b1);
      wait_done();
    end

    // Held button: exactly one decode.
    @(posedge clk); #1;
    xpos = 12'd730;
    ypos = 12'd400;
    left = 1'b1;
    push_expect(730, 400, cyc);
    repeat (50) @(posedge clk);
    #1 left = 1'b0;
    wait_done();

    // Second press while busy is dropped.
    click(890, 700, 1'b1);
    click(130, 60, 1'b0);
    wait_done();
    repeat (5) @(negedge clk);

    // Enable dropped during the row search.
    click(890, 700, 1'b0);
    repeat (4) @(posedge clk);
    #1 enable = 1'b0;
    @(negedge clk);
    check_val("busy_in_row", 32'(busy), 32'd1);
    @(negedge clk);
    check_val("busy_after_disable", 32'(busy), 32'd0);
    enable = 1'b1;
    repeat (12) @(negedge clk);
    check_val("addr_held", 32'(card_address), 32'(exp_addr));

    // Asynchronous reset mid-search.
    click(890, 700, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_val("arst_pressed", 32'(card_pressed), 32'd0);
    check_val("arst_miss", 32'(card_miss), 32'd0);
    check_val("arst_addr", 32'(card_address), 32'd0);
    check_val("arst_busy", 32'(busy), 32'd0);
    exp_addr = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    click(330, 230, 1'b1);
    wait_done();
    click(130, 40, 1'b1);
    wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
